// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   RESET_PC_DEF : default reset PC
//   NOP_INSTR    : encoding loaded into IF/ID for a bubble
//   PC_INC       : sequential fetch increment
//   fetch_entry_t: prefetch queue entry {fetch pc, instruction word}
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] PC_INC       = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // 32-bit modulo add; a PC of 32'hFFFF_FFFC plus 4 wraps to 0.
   function automatic logic [31:0] pc_plus(input logic [31:0] pc, input logic [31:0] n);
      return pc + n;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Latency: variable; the response for the oldest request arrives on imem_ack.
// Backpressure: none on the response path; the fetch side only issues when it can absorb the data.
//   imem_req   : fetch -> mem, request valid (address accepted on the clock edge)
//   imem_addr  : fetch -> mem, word-aligned fetch address
//   imem_ack   : mem -> fetch, read data valid this cycle
//   imem_rdata : mem -> fetch, instruction word
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit_fetch_queue.sv
// Prefetch queue: DEPTH-entry FIFO of {pc, instr} between imem responses and IF/ID.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: full is raised at DEPTH entries; pushes while full and pops while empty are ignored.
//   clk, reset          : clock, async active-high reset
//   push/push_dat       : write an entry
//   pop                 : drop the head entry
//   clear               : flush all entries (wins over push and pop)
//   head_dat/full/empty/count : queue state
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_dat,
   input  logic                     pop,
   input  logic                     clear,
   output fetch_entry_t             head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q;
   logic [AW-1:0]  rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic           push_ok;
   logic           pop_ok;

   assign push_ok = push & ~full & ~clear;
   assign pop_ok  = pop & ~empty & ~clear;

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while count says they are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat;
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign full     = (count_q == DEPTH[CW-1:0]);
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage + IF/ID register: owns the PC, fetches through a prefetch queue, redirects on branch/PC write.
// Latency: with a one-cycle memory, an instruction reaches IF/ID two edges after its request is issued.
// Backpressure: StallF/PCWrPendingF/full queue hold off requests; StallD holds IF/ID; redirect overrides both.
//   clk, reset                     : clock, async active-high reset
//   imem (master)                  : instruction-memory request/response
//   StallF, StallD, FlushD         : hazard-unit controls
//   PCWrPendingF                   : PC write in flight, suppress requests
//   BranchTakenD/BranchTargetD     : early branch redirect
//   PCSrcW/ResultW                 : writeback PC redirect (higher priority)
//   InstrD, PCPlus8D, ValidD       : IF/ID register contents
//   FetchStallF                    : decode would take a bubble (queue empty, decode not stalled)
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic                clk,
   input  logic                reset,
   fetch_unit_if.master        imem,
   input  logic                StallF,
   input  logic                StallD,
   input  logic                FlushD,
   input  logic                PCWrPendingF,
   input  logic                BranchTakenD,
   input  logic [31:0]         BranchTargetD,
   input  logic                PCSrcW,
   input  logic [31:0]         ResultW,
   output logic [31:0]         InstrD,
   output logic [31:0]         PCPlus8D,
   output logic                ValidD,
   output logic                FetchStallF
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   tag_q, tag_d;
   logic          out_q, out_d;
   logic          drop_q, drop_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pcp8_q, pcp8_d;
   logic          valid_q, valid_d;

   logic          redirect;
   logic [31:0]   target;
   logic [CW:0]   inflight;
   logic          issue;
   logic          ack_live;
   logic          id_take;
   logic          bypass;
   logic          q_push;
   logic          q_pop;
   fetch_entry_t  q_in;
   fetch_entry_t  q_head;
   logic          q_full;
   logic          q_empty;
   logic [CW-1:0] q_count;

   assign redirect = PCSrcW | BranchTakenD;
   assign target   = PCSrcW ? ResultW : BranchTargetD;

   // Only one request may be in flight, and it must have a queue slot reserved.
   assign inflight = {1'b0, q_count} + {{CW{1'b0}}, out_q};
   assign issue    = ~reset & ~StallF & ~PCWrPendingF & ~redirect & ~out_q & ~q_full
                     & (inflight < DEPTH_W);

   assign imem.imem_req  = issue;
   assign imem.imem_addr = pc_q;

   // A response is kept only when it answers a live (not dropped) request.
   assign ack_live = imem.imem_ack & out_q & ~drop_q;
   assign id_take  = ~redirect & ~FlushD & ~StallD;
   // Empty queue and a consumer ready: send the response straight into IF/ID.
   assign bypass   = id_take & q_empty & ack_live;
   assign q_in     = '{pc: tag_q, instr: imem.imem_rdata};
   assign q_push   = ack_live & ~bypass;
   assign q_pop    = id_take & ~q_empty;

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (q_push),
      .push_dat (q_in),
      .pop      (q_pop),
      .clear    (redirect),
      .head_dat (q_head),
      .full     (q_full),
      .empty    (q_empty),
      .count    (q_count)
   );

   assign FetchStallF = ~StallD & q_empty;

   // PC, outstanding-request and drop tracking.
   always_comb begin
      pc_d   = pc_q;
      tag_d  = tag_q;
      out_d  = out_q;
      drop_d = drop_q;

      if (redirect) begin
         pc_d = target;
      end else if (issue) begin
         pc_d  = pc_plus(pc_q, PC_INC);
         tag_d = pc_q;
      end

      if (issue)                         out_d = 1'b1;
      else if (imem.imem_ack & out_q)    out_d = 1'b0;

      // An ack retires the request whether it was kept or discarded; a redirect
      // with the request still pending marks its data as stale.
      if (imem.imem_ack & out_q)         drop_d = 1'b0;
      else if (redirect & out_q)         drop_d = 1'b1;
   end

   // IF/ID register.
   always_comb begin
      instr_d = instr_q;
      pcp8_d  = pcp8_q;
      valid_d = valid_q;

      if (redirect | FlushD) begin
         instr_d = NOP_INSTR;
         pcp8_d  = '0;
         valid_d = 1'b0;
      end else if (StallD) begin
         instr_d = instr_q;
      end else if (~q_empty) begin
         instr_d = q_head.instr;
         pcp8_d  = pc_plus(q_head.pc, 2 * PC_INC);
         valid_d = 1'b1;
      end else if (bypass) begin
         instr_d = imem.imem_rdata;
         pcp8_d  = pc_plus(tag_q, 2 * PC_INC);
         valid_d = 1'b1;
      end else begin
         instr_d = NOP_INSTR;
         pcp8_d  = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         tag_q   <= '0;
         out_q   <= 1'b0;
         drop_q  <= 1'b0;
         instr_q <= NOP_INSTR;
         pcp8_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         tag_q   <= tag_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         instr_q <= instr_d;
         pcp8_q  <= pcp8_d;
         valid_q <= valid_d;
      end
   end

   assign InstrD   = instr_q;
   assign PCPlus8D = pcp8_q;
   assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory, program-order instruction stream reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk = 1'b0;
   logic        reset;
   logic        StallF, StallD, FlushD, PCWrPendingF, BranchTakenD, PCSrcW;
   logic [31:0] BranchTargetD, ResultW;
   logic [31:0] InstrD, PCPlus8D;
   logic        ValidD, FetchStallF;

   always #5 clk = ~clk;

   fetch_unit_if imem_bus ();

   fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem          (imem_bus),
      .StallF        (StallF),
      .StallD        (StallD),
      .FlushD        (FlushD),
      .PCWrPendingF  (PCWrPendingF),
      .BranchTakenD  (BranchTakenD),
      .BranchTargetD (BranchTargetD),
      .PCSrcW        (PCSrcW),
      .ResultW       (ResultW),
      .InstrD        (InstrD),
      .PCPlus8D      (PCPlus8D),
      .ValidD        (ValidD),
      .FetchStallF   (FetchStallF)
   );

   // Instruction memory: content is a fixed function of the address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   logic        mem_busy = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_age  = 0;
   int          lat      = 1;
   logic        spur     = 1'b0;
   logic        force_ack = 1'b0;
   logic [31:0] junk     = 32'hDEAD_BEEF;
   logic [31:0] last_issue = '0;

   assign imem_bus.imem_ack   = (mem_busy && (mem_age >= lat - 1)) || (spur && !mem_busy) || force_ack;
   assign imem_bus.imem_rdata = mem_busy ? word_at(mem_addr) : junk;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_busy <= 1'b0;
         mem_age  <= 0;
      end else if (imem_bus.imem_req) begin
         mem_busy   <= 1'b1;
         mem_addr   <= imem_bus.imem_addr;
         mem_age    <= 0;
         last_issue <= imem_bus.imem_addr;
      end else if (mem_busy && imem_bus.imem_ack) begin
         mem_busy <= 1'b0;
      end else if (mem_busy) begin
         mem_age <= mem_age + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: next program-order PC for decode, next fetch address, last IF/ID view.
   logic [31:0] exp_pc, fpc, last_instr, last_pcp8;
   logic        last_valid;
   int          delivered = 0;

   task automatic model_reset();
      exp_pc     = RST_PC;
      fpc        = RST_PC;
      last_instr = '0;
      last_pcp8  = '0;
      last_valid = 1'b0;
   endtask

   task automatic set_idle();
      StallF = 0; StallD = 0; FlushD = 0; PCWrPendingF = 0;
      BranchTakenD = 0; PCSrcW = 0; BranchTargetD = '0; ResultW = '0;
      spur = 0; force_ack = 0;
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic cyc();
      logic        p_redir, p_flush, p_stalld, p_issue;
      logic [31:0] p_tgt;
      #1;
      p_redir  = PCSrcW | BranchTakenD;
      p_tgt    = PCSrcW ? ResultW : BranchTargetD;
      p_flush  = FlushD;
      p_stalld = StallD;
      p_issue  = imem_bus.imem_req;
      if (StallF | PCWrPendingF | p_redir) chk("req_blocked", imem_bus.imem_req, 0);
      if (p_issue) chk("req_addr", imem_bus.imem_addr, fpc);
      if (StallD) chk("fstall_when_stalld", FetchStallF, 0);
      if (p_issue) fpc = fpc + 32'd4;
      if (p_redir) fpc = p_tgt;
      @(posedge clk);
      @(negedge clk);
      if (p_redir) begin
         chk("redir_valid", ValidD, 0);
         chk("redir_instr", InstrD, 0);
         exp_pc = p_tgt;
      end else if (p_flush) begin
         chk("flush_valid", ValidD, 0);
         chk("flush_instr", InstrD, 0);
      end else if (p_stalld) begin
         chk("hold_valid", ValidD, last_valid);
         chk("hold_instr", InstrD, last_instr);
         chk("hold_pcp8", PCPlus8D, last_pcp8);
      end else if (ValidD) begin
         chk("seq_pcp8", PCPlus8D, exp_pc + 32'd8);
         chk("seq_instr", InstrD, word_at(exp_pc));
         exp_pc = exp_pc + 32'd4;
         delivered++;
      end else begin
         chk("bubble_instr", InstrD, 0);
      end
      last_instr = InstrD;
      last_pcp8  = PCPlus8D;
      last_valid = ValidD;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b1;
      #1;
      chk("rst_valid", ValidD, 0);
      chk("rst_instr", InstrD, 0);
      chk("rst_pcp8", PCPlus8D, 0);
      chk("rst_req", imem_bus.imem_req, 0);
      chk("rst_fstall", FetchStallF, 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int d0;
      bit found;
      logic [31:0] exp_addr;

      reset = 1'b1;
      set_idle();
      @(negedge clk);

      // 1: one-cycle memory, no stalls.
      lat = 1;
      do_reset();
      #1;
      chk("t1_req_c0", imem_bus.imem_req, 1);
      chk("t1_addr_c0", imem_bus.imem_addr, RST_PC);
      d0 = delivered;
      cyc();
      chk("t1_valid_c1", ValidD, 0);
      chk("t1_fstall_c1", FetchStallF, 1);
      cyc();
      chk("t1_valid_c2", ValidD, 1);
      repeat (4) cyc();
      chk("t1_count", delivered - d0, 3);

      // 2: decode stalled with 3-cycle memory; queue fills and requests stop.
      lat = 3;
      repeat (4) cyc();
      StallD = 1;
      repeat (10) cyc();
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t2_req_full", imem_bus.imem_req, 0);
         cyc();
      end
      StallD = 0;
      cyc();
      chk("t2_pop1_valid", ValidD, 1);
      cyc();
      chk("t2_pop2_valid", ValidD, 1);
      repeat (8) cyc();

      // 3: branch while the request to 0x20 is outstanding.
      do_reset();
      lat = 3;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         #1;
         if (mem_busy && mem_addr == 32'h20 && !imem_bus.imem_ack) found = 1;
         else cyc();
      end
      chk("t3_found_0x20", found, 1);
      BranchTakenD = 1; BranchTargetD = 32'h100;
      cyc();
      BranchTakenD = 0; BranchTargetD = '0;
      for (int i = 0; i < 40 && !ValidD; i++) cyc();
      chk("t3_valid_seen", ValidD, 1);
      chk("t3_pcp8", PCPlus8D, 32'h108);
      repeat (4) cyc();

      // 4: simultaneous writeback and branch redirects.
      lat = 2;
      PCSrcW = 1; ResultW = 32'h40; BranchTakenD = 1; BranchTargetD = 32'h80;
      cyc();
      set_idle();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         #1;
         if (imem_bus.imem_req) found = 1;
         else cyc();
      end
      chk("t4_req_seen", found, 1);
      chk("t4_addr", imem_bus.imem_addr, 32'h40);
      repeat (6) cyc();

      // 5: PC write pending holds off fetch without moving the PC.
      lat = 1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         #1;
         if (!mem_busy) found = 1;
         else cyc();
      end
      chk("t5_idle_seen", found, 1);
      exp_addr = last_issue + 32'd4;
      PCWrPendingF = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t5_req_held", imem_bus.imem_req, 0);
         cyc();
      end
      PCWrPendingF = 0;
      #1;
      chk("t5_req_resume", imem_bus.imem_req, 1);
      chk("t5_addr_resume", imem_bus.imem_addr, exp_addr);
      repeat (6) cyc();

      // 6: reset mid-request with an ack while reset is high.
      lat = 3;
      for (int i = 0; i < 20 && !ValidD; i++) cyc();
      StallD = 1;
      for (int i = 0; i < 20 && !mem_busy; i++) cyc();
      chk("t6_busy_valid", {31'b0, mem_busy & ValidD}, 1);
      reset = 1'b1;
      #1;
      chk("t6_async_valid", ValidD, 0);
      chk("t6_async_instr", InstrD, 0);
      chk("t6_async_pcp8", PCPlus8D, 0);
      chk("t6_async_req", imem_bus.imem_req, 0);
      force_ack = 1; junk = 32'hBAD0_BAD0;
      @(negedge clk);
      @(negedge clk);
      force_ack = 0; StallD = 0;
      reset = 1'b0;
      model_reset();
      #1;
      chk("t6_req_after", imem_bus.imem_req, 1);
      chk("t6_addr_after", imem_bus.imem_addr, RST_PC);
      repeat (10) cyc();

      // Randomised traffic against the program-order reference.
      d0 = delivered;
      for (int n = 0; n < 3000; n++) begin
         StallF        = ($urandom_range(0, 9) == 0);
         StallD        = ($urandom_range(0, 3) == 0);
         FlushD        = ($urandom_range(0, 19) == 0);
         PCWrPendingF  = ($urandom_range(0, 19) == 0);
         BranchTakenD  = ($urandom_range(0, 29) == 0);
         BranchTargetD = 32'($urandom_range(0, 255)) << 2;
         if ($urandom_range(0, 3) == 0) BranchTargetD = 32'hFFFF_FFF0;
         PCSrcW        = ($urandom_range(0, 49) == 0);
         ResultW       = 32'($urandom_range(0, 255)) << 2;
         lat           = $urandom_range(1, 4);
         junk          = $urandom;
         spur          = !mem_busy && ($urandom_range(0, 7) == 0);
         cyc();
      end
      set_idle();
      repeat (10) cyc();
      chk("rand_progress", {31'b0, (delivered - d0) >= 100}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
